// File: rtl/midi_sw_pkg.sv
// Shared definitions for the MIDI switcher: frame geometry, SPI receiver
// state encoding and default timing limits.
package midi_sw_pkg;

  localparam int FRAME_BITS_DEF     = 48;
  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  // Receiver state encoding, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Width needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-stage synchroniser for one asynchronous pin, with registered rise/fall
// strobes derived from one further register on the synchronised level.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // NOTE: every *_d is assigned on every path through the comb block, so no
  // latch can be inferred here or in any other next-state block.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values together; blocking here would chain the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave front end: synchronises the SPI pins, deserialises fixed-length
// routing frames and shifts the previously accepted frame back out on MISO.
module spi_frame_rx
  import midi_sw_pkg::*;
#(
  parameter int FRAME_BITS     = FRAME_BITS_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_ss,
  output logic                  spi_miso,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam int CNT_W = cnt_width(FRAME_BITS);
  localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ss_s, ss_rise, ss_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (spi_clk),
    .dout  (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (spi_mosi),
    .dout  (mosi_s),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  // Slave select idles high, so its stages come out of reset deasserted.
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk   (clk),
    .reset (reset),
    .din   (spi_ss),
    .dout  (ss_s),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // Only the SPI clock needs edges; the level of that line is not used.
  assign unused_edges = &{1'b0, sclk_s, mosi_rise, mosi_fall, ss_rise, ss_fall};

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [FRAME_BITS-1:0] rx_next;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_d         = tmo_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    rx_next       = {rx_sr_q[FRAME_BITS-2:0], mosi_s};

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (!ss_s) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = '0;
          tx_sr_d   = frame_data_q;
        end
      end

      default: begin
        if (sclk_fall) begin
          rx_sr_d = rx_next;
          tmo_d   = '0;
          if (bit_cnt_q == LAST_BIT) begin
            // The completed frame becomes the readback for the next transfer.
            frame_data_d  = rx_next;
            frame_valid_d = 1'b1;
            bit_cnt_d     = '0;
            tx_sr_d       = rx_next;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end else if (sclk_rise) begin
          tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
          tmo_d   = '0;
        end else if (bit_cnt_q == '0) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
          // Stalled mid-frame: drop the partial frame but stay selected.
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end

        // Deselect is judged after this cycle's bit, so a frame completing
        // together with the ss rise is kept and raises no error.
        if (ss_s) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
          if (bit_cnt_d != '0) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign spi_miso    = tx_sr_q[FRAME_BITS-1];
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: a host model drives SPI transfers while a monitor
// matches every frame_valid / frame_err strobe against a queue of expectations.
`timescale 1ns/1ps
module tb_spi_frame_rx;

  localparam int FB = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_clk, spi_mosi, spi_ss;
  logic          spi_miso;
  logic [FB-1:0] frame_data;
  logic          frame_valid, frame_err;

  always #62.5 clk = ~clk;  // 8 MHz system clock

  spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2), .TIMEOUT_CYCLES(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_ss      (spi_ss),
    .spi_miso    (spi_miso),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  typedef struct {
    bit            is_err;
    logic [FB-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [FB-1:0] model_frame;  // frame the receiver should currently hold

  task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {frame_valid, frame_err}, '0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {frame_valid, frame_err}, e.is_err ? 2'b01 : 2'b10);
          if (!e.is_err) check("frame_data", frame_data, e.data);
        end
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One SPI half period at 1 MHz is four system clocks.
  task automatic half_period();
    repeat (4) @(negedge clk);
  endtask

  task automatic select();
    spi_ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic deselect();
    repeat (8) @(negedge clk);
    spi_ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Shifts the top nbits of word MSB first, pausing gap clocks after each
  // byte. MISO is read at the end of every low phase, i.e. the bit the
  // receiver presents for the host's sample of that bit.
  task automatic xfer(input logic [FB-1:0] word, input int nbits, input int gap,
                      output logic [FB-1:0] rb);
    rb = '0;
    for (int i = 0; i < nbits; i++) begin
      rb       = {rb[FB-2:0], spi_miso};
      spi_mosi = word[FB-1-i];
      spi_clk  = 1'b1;
      half_period();
      spi_clk  = 1'b0;
      half_period();
      if (i % 8 == 7) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [FB-1:0] word, input int gap, input bit check_rb,
                            input string name);
    logic [FB-1:0] rb;
    exp_q.push_back('{1'b0, word});
    xfer(word, FB, gap, rb);
    if (check_rb) check(name, rb, model_frame);
    model_frame = word;
  endtask

  initial begin
    logic [FB-1:0] rb, w, m0;
    int            lat, changes, nb;

    reset = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_ss = 1'b1;
    model_frame = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_frame_data", frame_data, '0);
    check("reset_miso", spi_miso, 1'b0);
    check("reset_strobes", {frame_valid, frame_err}, 2'b00);

    // Nominal frame with 1 us blanks between bytes.
    select();
    send_frame(48'h0056_DEAD_BEEF, 8, 1'b1, "readback_nominal");
    deselect();
    check("nominal_held", frame_data, 48'h0056_DEAD_BEEF);

    // Back-to-back frames under one select; the second reads back the first.
    select();
    send_frame(48'h0056_DEAD_BEEF, 8, 1'b1, "readback_b2b_first");
    send_frame(48'h1234_5678_9ABC, 8, 1'b1, "readback_b2b_second");
    deselect();
    check("b2b_held", frame_data, 48'h1234_5678_9ABC);

    // Deselect after 20 bits aborts the frame and keeps the previous one.
    select();
    exp_q.push_back('{1'b1, '0});
    xfer(48'hCAFE_F00D_1234, 20, 8, rb);
    check("abort_partial_readback", rb[19:0], model_frame[FB-1 -: 20]);
    deselect();
    check("abort_data_kept", frame_data, model_frame);
    select();
    send_frame(48'hFFFF_FFFF_FFFF, 8, 1'b1, "readback_after_abort");
    deselect();

    // Clock stalls after 30 bits with ss held low.
    select();
    exp_q.push_back('{1'b1, '0});
    xfer(48'h5555_AAAA_3333, 30, 0, rb);
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (frame_err) begin
        lat = c + 4;  // clocks since the final falling pin edge
        break;
      end
    end
    n_cmp++;
    if (lat < 257 || lat > 261) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d clocks, expected 257..261", lat);
    end
    check("timeout_data_kept", frame_data, model_frame);
    send_frame(48'h0000_0000_0001, 8, 1'b0, "");
    deselect();
    check("after_timeout_held", frame_data, 48'h0000_0000_0001);

    // Reset pulse mid-frame discards everything silently.
    select();
    xfer(48'h0F0F_0F0F_0F0F, 10, 8, rb);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_frame_data", frame_data, '0);
    check("midreset_miso", spi_miso, 1'b0);
    check("midreset_strobes", {frame_valid, frame_err}, 2'b00);
    reset = 1'b0;
    model_frame = '0;
    repeat (4) @(negedge clk);
    deselect();
    select();
    send_frame(48'hA5A5_A5A5_A5A5, 8, 1'b1, "readback_after_reset");
    deselect();

    // SPI clock toggling while deselected must be ignored.
    m0 = '0;
    m0[0] = spi_miso;
    changes = 0;
    for (int i = 0; i < 48; i++) begin
      spi_mosi = i[0];
      spi_clk  = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (spi_miso !== m0[0]) changes++;
      end
      spi_clk = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (spi_miso !== m0[0]) changes++;
      end
    end
    check("idle_miso_static", changes, 0);
    check("idle_data_kept", frame_data, model_frame);

    // Randomised sessions: random data, byte gaps and occasional aborts.
    for (int s = 0; s < 5; s++) begin
      select();
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        w = FB'({$urandom(), $urandom()});
        send_frame(w, $urandom_range(0, 12), 1'b1, "readback_random");
      end
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(1, 47);
        w  = FB'({$urandom(), $urandom()});
        exp_q.push_back('{1'b1, '0});
        xfer(w, nb, $urandom_range(0, 12), rb);
        check("random_partial_readback", rb & ((48'h1 << nb) - 1), model_frame >> (FB - nb));
      end
      deselect();
      check("random_held", frame_data, model_frame);
    end

    repeat (20) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
